led_status_ctrl: RTL and testbench
==================================

// Module: led_status_ctrl
// PURPOSE
//  Multi-channel board status LED driver; parametrised successor of the fixed
//  free-running blink counters. Each channel selects OFF/ON/BLINK/HEARTBEAT/
//  ACTIVITY at run time. One shared prescaler produces a slow tick for all
//  channels. Sits at top level between system control/status logic and LED pins.
// PARAMETERS
//  N_LED        2       number of LED channels
//  TICK_DIV     50000   clk_i cycles per tick (1 kHz at 50 MHz); must be >= 2
//  PER_W        16      width of blink half-period and of per-channel counters
//  HB_ON        100     heartbeat flash length, ticks
//  HB_PERIOD    1000    heartbeat repeat period, ticks; must be > 4*HB_ON
//  STRETCH      50      activity pulse-stretch length, ticks
// PORTS
//  clk_i     in   1          system clock, sole clock domain
//  rst_n_i   in   1          reset, asynchronous assert, active-low
//  mode_i    in   3*N_LED    per-channel mode; channel k = mode_i[3k+2:3k]
//  period_i  in   PER_W      shared BLINK half-period in ticks; 0 treated as 1
//  act_i     in   N_LED      per-channel activity strobe, sync to clk_i, any width
//  tick_o    out  1          one-cycle prescaler tick, for debug/other timers
//  led_o     out  N_LED      LED drive, 1 = lit, registered
// BEHAVIOUR
//  Reset: prescaler=0, all channel counters=0, tick_o=0, led_o=0.
//  Prescaler: counts 0..TICK_DIV-1 then wraps to 0; tick_o=1 on exactly the cycle
//   after count==TICK_DIV-1 (registered), period TICK_DIV cycles.
//  Modes: 0 OFF, 1 ON, 2 BLINK, 3 HEARTBEAT, 4 ACTIVITY, 5-7 reserved = OFF.
//  Mode change: each channel registers its previous mode; on a mismatch,
//   that channel's phase counter and blink state clear to 0 in that cycle, and
//   the new mode starts at phase 0. Stretch counter is NOT cleared by mode change.
//  Latency: led_o is registered; it reflects mode_i/act_i/tick 1 cycle later.
//  OFF/reserved: led_o=0. ON: led_o=1.
//  BLINK: phase counter incremented on tick; when it reaches max(period_i,1)-1
//   on a tick it clears and blink state toggles. Starts unlit. period_i change
//   takes effect on the next comparison (no restart); if phase already exceeds
//   new period-1, the next tick clears and toggles.
//  HEARTBEAT: phase counts ticks 0..HB_PERIOD-1 and wraps. Lit for phase in
//   [0,HB_ON) and [2*HB_ON,3*HB_ON), else unlit.
//  ACTIVITY: per-channel stretch counter (always running, all modes) loaded with
//   STRETCH on any cycle act_i=1; otherwise decremented on tick while non-zero.
//   Load and tick in the same cycle: load wins. Lit while counter != 0.
//   Continuous act_i holds LED lit; extinguishes STRETCH ticks after last strobe
//   (+/-1 tick granularity).
//  Counter widths: phase and stretch counters PER_W bits; no overflow possible
//   since HB_PERIOD, STRETCH < 2**PER_W (elaboration-time assertion).
//  Reset mid-operation: immediate return to reset state; no pending state kept.
// STRUCTURE
//  Package led_pkg: led_mode_e enum (LED_OFF=0..LED_ACT=4), MODE_W=3 constant.
//  Sub-module led_chan: one channel (mode register, phase counter, blink state,
//   stretch counter, output register); instantiated N_LED times in a generate
//   loop. Prescaler inline in led_status_ctrl; tick fanned to all channels.
//  Parameter checks via elaboration-time assertions (TICK_DIV>=2,
//   HB_PERIOD>4*HB_ON, values fit PER_W).
// TESTING  (bench uses TICK_DIV=4, HB_ON=2, HB_PERIOD=10, STRETCH=3, N_LED=2)
//  Reset: hold rst_n_i=0 with mode ON -> led_o=0, tick_o=0; release -> led_o=2'b11
//   one cycle later, tick_o pulses every 4 cycles.
//  BLINK period_i=3 on ch0 -> led_o[0] toggles every 3 ticks (12 cycles), starts 0;
//   period_i=0 -> toggles every tick.
//  HEARTBEAT on ch1 -> led_o[1] pattern per tick 1,1,0,0,1,1,0,0,0,0 repeating.
//  ACTIVITY: single-cycle act_i[0] -> lit next cycle, unlit after 3 ticks; second
//   strobe coincident with tick at count 1 -> counter reloads to 3, stays lit.
//  Mode change BLINK->HEARTBEAT mid-phase -> phase restarts, flash begins at once;
//   mode 6 -> led_o=0.
//  Async reset asserted mid-blink between clock edges -> led_o=0 immediately.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types for the status LED driver.
//   led_mode_e : per-channel mode encoding (values 5-7 are reserved and read as OFF)
//   MODE_W     : width of one channel's mode field
package led_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    LED_OFF       = 3'd0,
    LED_ON        = 3'd1,
    LED_BLINK     = 3'd2,
    LED_HEARTBEAT = 3'd3,
    LED_ACT       = 3'd4
  } led_mode_e;

endpackage

// File: rtl/led_chan.sv
// One LED channel: mode tracking, phase counter, blink state, activity
// stretch counter and registered LED output.
//   clk_i, rst_n_i : clock, async active-low reset
//   tick_i         : one-cycle slow tick from the shared prescaler
//   mode_i         : this channel's mode
//   period_i       : BLINK half-period in ticks (0 behaves as 1)
//   act_i          : activity strobe
//   led_o          : registered LED drive, 1 = lit
module led_chan
  import led_pkg::*;
#(
  parameter int unsigned PER_W     = 16,
  parameter int unsigned HB_ON     = 100,
  parameter int unsigned HB_PERIOD = 1000,
  parameter int unsigned STRETCH   = 50
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              tick_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [PER_W-1:0]  period_i,
  input  logic              act_i,
  output logic              led_o
);

  logic [MODE_W-1:0] r_mode;
  logic [PER_W-1:0]  r_phase;
  logic [PER_W-1:0]  r_stretch;
  logic              r_blink;
  logic              r_led;

  logic [PER_W-1:0]  w_per_m1;
  logic [PER_W-1:0]  w_phase_d;
  logic [PER_W-1:0]  w_stretch_d;
  logic              w_blink_d;
  logic              w_led_d;

  // Next-state and LED decode; the LED is decoded from next-state values so
  // that a mode change or strobe shows on the output one cycle later.
  always_comb begin
    w_per_m1    = (period_i == '0) ? '0 : period_i - PER_W'(1);
    w_phase_d   = r_phase;
    w_blink_d   = r_blink;
    w_stretch_d = r_stretch;
    w_led_d     = 1'b0;

    if (mode_i != r_mode) begin
      w_phase_d = '0;
      w_blink_d = 1'b0;
    end else if (tick_i) begin
      case (mode_i)
        LED_BLINK: begin
          // >= so a shortened period takes effect on the very next tick
          if (r_phase >= w_per_m1) begin
            w_phase_d = '0;
            w_blink_d = ~r_blink;
          end else begin
            w_phase_d = r_phase + PER_W'(1);
          end
        end
        LED_HEARTBEAT: begin
          w_phase_d = (r_phase == PER_W'(HB_PERIOD - 1)) ? '0 : r_phase + PER_W'(1);
        end
        default: ;
      endcase
    end

    // Stretch counter runs in every mode; a strobe beats a tick.
    if (act_i) begin
      w_stretch_d = PER_W'(STRETCH);
    end else if (tick_i && (r_stretch != '0)) begin
      w_stretch_d = r_stretch - PER_W'(1);
    end

    case (mode_i)
      LED_ON:        w_led_d = 1'b1;
      LED_BLINK:     w_led_d = w_blink_d;
      LED_HEARTBEAT: w_led_d = (w_phase_d < PER_W'(HB_ON)) ||
                               ((w_phase_d >= PER_W'(2 * HB_ON)) &&
                                (w_phase_d <  PER_W'(3 * HB_ON)));
      LED_ACT:       w_led_d = (w_stretch_d != '0);
      default:       w_led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mode    <= '0;
      r_phase   <= '0;
      r_stretch <= '0;
      r_blink   <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_mode    <= mode_i;
      r_phase   <= w_phase_d;
      r_stretch <= w_stretch_d;
      r_blink   <= w_blink_d;
      r_led     <= w_led_d;
    end
  end

  assign led_o = r_led;

endmodule

// File: rtl/led_status_ctrl.sv
// Multi-channel board status LED driver with a shared slow-tick prescaler.
//   clk_i, rst_n_i : clock, async active-low reset
//   mode_i         : per-channel mode, channel k in mode_i[3k+2:3k]
//   period_i       : shared BLINK half-period in ticks (0 behaves as 1)
//   act_i          : per-channel activity strobes
//   tick_o         : registered one-cycle prescaler tick
//   led_o          : registered LED drive per channel, 1 = lit
module led_status_ctrl
  import led_pkg::*;
#(
  parameter int unsigned N_LED     = 2,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned PER_W     = 16,
  parameter int unsigned HB_ON     = 100,
  parameter int unsigned HB_PERIOD = 1000,
  parameter int unsigned STRETCH   = 50
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [MODE_W*N_LED-1:0]   mode_i,
  input  logic [PER_W-1:0]          period_i,
  input  logic [N_LED-1:0]          act_i,
  output logic                      tick_o,
  output logic [N_LED-1:0]          led_o
);

  localparam int unsigned      CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam longint unsigned  PER_LIM = 64'd1 << PER_W;

  // Parameter sanity checks
  if (TICK_DIV < 2) begin : g_chk_div
    $error("led_status_ctrl: TICK_DIV must be >= 2");
  end
  if (HB_PERIOD <= 4 * HB_ON) begin : g_chk_hb
    $error("led_status_ctrl: HB_PERIOD must exceed 4*HB_ON");
  end
  if ((64'(HB_PERIOD) >= PER_LIM) || (64'(STRETCH) >= PER_LIM) ||
      (64'(3 * HB_ON) >= PER_LIM)) begin : g_chk_w
    $error("led_status_ctrl: HB_PERIOD/HB_ON/STRETCH do not fit PER_W");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));

  // Shared prescaler; tick is registered so it lands the cycle after the wrap
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_tick <= w_wrap;
    end
  end

  assign tick_o = r_tick;

  for (genvar g = 0; g < N_LED; g++) begin : g_chan
    led_chan #(
      .PER_W     (PER_W),
      .HB_ON     (HB_ON),
      .HB_PERIOD (HB_PERIOD),
      .STRETCH   (STRETCH)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .tick_i   (r_tick),
      .mode_i   (mode_i[MODE_W*g +: MODE_W]),
      .period_i (period_i),
      .act_i    (act_i[g]),
      .led_o    (led_o[g])
    );
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl: the driver updates a behavioural
// model per clock and queues the expected {tick_o, led_o}; a monitor pops
// and compares one entry per clock.
module tb_led_status_ctrl;

  localparam int unsigned N    = 2;
  localparam int unsigned TD   = 4;
  localparam int unsigned PW   = 16;
  localparam int unsigned HBON = 2;
  localparam int unsigned HBP  = 10;
  localparam int unsigned ST   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3*N-1:0] mode;
  logic [PW-1:0] per;
  logic [N-1:0]  act;
  logic          tick;
  logic [N-1:0]  led;

  always #5 clk = ~clk;

  led_status_ctrl #(
    .N_LED(N), .TICK_DIV(TD), .PER_W(PW), .HB_ON(HBON), .HB_PERIOD(HBP), .STRETCH(ST)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode), .period_i(per),
    .act_i(act), .tick_o(tick), .led_o(led)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];

  // model state
  int m_edge;
  int m_prev[N];
  int m_ticks[N];   // ticks seen since the current mode was entered
  int m_bph[N];     // ticks since last blink toggle
  int m_blink[N];
  int m_str[N];

  // currently driven stimulus
  int d_mode[N];
  int d_per;
  logic [N-1:0] d_act;

  task automatic chk(input string name, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_edge = 0;
    for (int c = 0; c < N; c++) begin
      m_prev[c] = 0; m_ticks[c] = 0; m_bph[c] = 0; m_blink[c] = 0; m_str[c] = 0;
    end
  endfunction

  function automatic bit hb_lit(input int t);
    int slot;
    slot = (t % HBP) / HBON;
    return (slot == 0) || (slot == 2);
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_step();
    bit tk;
    int hp;
    logic [N-1:0] l;
    tk = (m_edge > 0) && (m_edge % TD == 0);
    m_edge++;
    hp = (d_per == 0) ? 1 : d_per;
    for (int c = 0; c < N; c++) begin
      if (d_mode[c] != m_prev[c]) begin
        m_ticks[c] = 0; m_bph[c] = 0; m_blink[c] = 0;
      end else if (tk) begin
        m_ticks[c]++;
        if (d_mode[c] == 2) begin
          if (m_bph[c] + 1 >= hp) begin
            m_bph[c] = 0;
            m_blink[c] = 1 - m_blink[c];
          end else begin
            m_bph[c]++;
          end
        end
      end
      m_prev[c] = d_mode[c];
      if (d_act[c])              m_str[c] = ST;
      else if (tk && m_str[c] > 0) m_str[c]--;
      case (d_mode[c])
        1:       l[c] = 1'b1;
        2:       l[c] = m_blink[c][0];
        3:       l[c] = hb_lit(m_ticks[c]);
        4:       l[c] = (m_str[c] != 0);
        default: l[c] = 1'b0;
      endcase
    end
    exp_q.push_back({(m_edge % TD == 0), l});
  endfunction

  task automatic drive(input int m0, input int m1, input int p, input logic [N-1:0] a);
    @(negedge clk);
    rst_n = 1'b1;
    d_mode[0] = m0; d_mode[1] = m1; d_per = p; d_act = a;
    mode = {3'(m1), 3'(m0)};
    per  = PW'(p);
    act  = a;
    @(posedge clk);
    model_step();
  endtask

  task automatic run(input int n, input int m0, input int m1, input int p);
    for (int i = 0; i < n; i++) drive(m0, m1, p, '0);
  endtask

  // monitor
  logic [2:0] mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("led_o", int'(led), int'(mon_e[1:0]));
        chk("tick_o", int'(tick), int'(mon_e[2]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int rm[N];
    model_reset();
    rst_n = 1'b0;
    d_mode[0] = 1; d_mode[1] = 1; d_per = 0; d_act = '0;
    mode = 6'b001_001; per = '0; act = '0;
    repeat (3) @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_tick", int'(tick), 0);

    // ON on both channels, then blink / heartbeat
    run(12, 1, 1, 0);
    run(60, 2, 3, 3);
    run(20, 2, 3, 0);

    // single activity strobe on ch0
    drive(4, 3, 0, 2'b01);
    run(20, 4, 3, 0);
    drive(4, 3, 0, 2'b01);
    // re-strobe exactly when a tick would take the counter from 1 to 0
    guard = 0;
    while (!((m_edge % TD == 0) && (m_str[0] == 1)) && guard < 40) begin
      drive(4, 3, 0, '0);
      guard++;
    end
    chk("restrobe_reached", int'(guard < 40), 1);
    drive(4, 3, 0, 2'b01);
    run(20, 4, 3, 0);

    // blink then mid-phase switch to heartbeat; then reserved mode
    run(30, 2, 0, 5);
    run(30, 3, 6, 5);
    run(8, 6, 6, 5);

    // randomized modes, periods and strobes
    rm[0] = 2; rm[1] = 3;
    for (int i = 0; i < 500; i++) begin
      logic [N-1:0] a;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 19) == 0) rm[c] = $urandom_range(0, 7);
        a[c] = ($urandom_range(0, 9) == 0);
      end
      drive(rm[0], rm[1], (i % 40 < 20) ? 2 : int'($urandom_range(0, 4)), a);
    end

    // async reset mid-blink between clock edges
    run(17, 2, 1, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", int'(led), 0);
    chk("async_rst_tick", int'(tick), 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("held_rst_led", int'(led), 0);
    run(30, 2, 3, 2);

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
